// File: rtl/banana_pkg.sv
// banana_pkg
// Shared definitions for the object-position fetch path. The CPU software
// constants and the VGA side both use the position addresses defined here, so
// they stay in agreement.
//   - state_t        : fetch sequencer state encoding (2 bits)
//   - idx_t          : position-word index (3 bits, 0..5 legal)
//   - DEF_*          : default memory addresses of the six position words
//   - idx_next()     : successor index, table driven (no adder)
//   - idx_legal()    : high only for indices 0..5
package banana_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   localparam int NUM_POS_WORDS = 6;

   typedef logic [2:0] idx_t;

   localparam idx_t IDX_MX  = 3'd0;
   localparam idx_t IDX_MY  = 3'd1;
   localparam idx_t IDX_P1X = 3'd2;
   localparam idx_t IDX_P1Y = 3'd3;
   localparam idx_t IDX_P2X = 3'd4;
   localparam idx_t IDX_P2Y = 3'd5;

   localparam int unsigned DEF_MXP  = 6000;
   localparam int unsigned DEF_MYP  = 6004;
   localparam int unsigned DEF_P1XP = 6008;
   localparam int unsigned DEF_P1YP = 6012;
   localparam int unsigned DEF_P2XP = 6016;
   localparam int unsigned DEF_P2YP = 6020;

   function automatic idx_t idx_next(input idx_t i);
      case (i)
         IDX_MX:  idx_next = IDX_MY;
         IDX_MY:  idx_next = IDX_P1X;
         IDX_P1X: idx_next = IDX_P1Y;
         IDX_P1Y: idx_next = IDX_P2X;
         IDX_P2X: idx_next = IDX_P2Y;
         default: idx_next = IDX_MX;
      endcase
   endfunction

   function automatic logic idx_legal(input idx_t i);
      case (i)
         IDX_MX, IDX_MY, IDX_P1X, IDX_P1Y, IDX_P2X, IDX_P2Y: idx_legal = 1'b1;
         default: idx_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pos_fetch_ctrl_if.sv
// pos_fetch_ctrl_if
// Bundle between the fetch sequencer, memory port A and the VGA renderer.
//   frame_start           : one-cycle pulse at start of vertical blank
//   addr_a / data_a       : memory port A read address / read data
//   mx,my,p1x,p1y,p2x,p2y : committed positions to the renderer
//   busy, done, overrun   : sequencer status
// master = sequencer side, slave = memory/renderer/timing side.
interface pos_fetch_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             frame_start;
   logic [WIDTH-1:0] addr_a;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] mx;
   logic [WIDTH-1:0] my;
   logic [WIDTH-1:0] p1x;
   logic [WIDTH-1:0] p1y;
   logic [WIDTH-1:0] p2x;
   logic [WIDTH-1:0] p2y;
   logic             busy;
   logic             done;
   logic             overrun;

   modport master (
      input  frame_start, data_a,
      output addr_a, mx, my, p1x, p1y, p2x, p2y, busy, done, overrun
   );

   modport slave (
      output frame_start, data_a,
      input  addr_a, mx, my, p1x, p1y, p2x, p2y, busy, done, overrun
   );
endinterface

// File: rtl/flopenr.sv
// flopenr
// Enabled register with synchronous active-high reset to zero.
//   i_clk, i_reset : clock, synchronous reset
//   i_en           : load enable
//   i_d / o_q      : data in / registered data out
module flopenr #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_reset)   r_q <= '0;
      else if (i_en) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/pos_tag_pipe.sv
// pos_tag_pipe
// READ_LATENCY-deep shift register of {valid, idx}. A tag pushed alongside an
// address emerges in the same cycle the memory returns that address's data.
//   i_clk, i_reset : clock, synchronous reset (flushes all tags)
//   i_vld, i_idx   : tag entering with the issued address
//   o_vld, o_idx   : tag aligned with data_a
module pos_tag_pipe
   import banana_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_vld,
   input  idx_t i_idx,
   output logic o_vld,
   output idx_t o_idx
);

   logic r_vld [READ_LATENCY];
   idx_t r_idx [READ_LATENCY];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_vld[i] <= 1'b0;
            r_idx[i] <= '0;
         end
      end else begin
         r_vld[0] <= i_vld;
         r_idx[0] <= i_idx;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_idx[i] <= r_idx[i-1];
         end
      end
   end

   assign o_vld = r_vld[READ_LATENCY-1];
   assign o_idx = r_idx[READ_LATENCY-1];

endmodule

// File: rtl/pos_fetch_ctrl.sv
// pos_fetch_ctrl
// Once per frame, reads the six object-position words from memory port A into
// shadow registers, then commits all six to the renderer on a single edge so
// a frame never sees a partially updated position set.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : pos_fetch_ctrl_if master (frame_start, memory port A,
//                committed positions, busy/done/overrun)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for frame_start, addr_a parked on MXP
// ST_FETCH  | issuing one read per cycle, idx 0..5
// ST_DRAIN  | waiting for the last read (P2Y) to return
// ST_COMMIT | copying shadows to outputs; done follows next cycle
module pos_fetch_ctrl
   import banana_pkg::*;
#(
   parameter int          WIDTH        = 16,
   parameter int          READ_LATENCY = 1,
   parameter int unsigned MXP          = DEF_MXP,
   parameter int unsigned MYP          = DEF_MYP,
   parameter int unsigned P1XP         = DEF_P1XP,
   parameter int unsigned P1YP         = DEF_P1YP,
   parameter int unsigned P2XP         = DEF_P2XP,
   parameter int unsigned P2YP         = DEF_P2YP
) (
   input  logic              clk,
   input  logic              reset,
   pos_fetch_ctrl_if.master  bus
);

   localparam logic [WIDTH-1:0] A_MX  = WIDTH'(MXP);
   localparam logic [WIDTH-1:0] A_MY  = WIDTH'(MYP);
   localparam logic [WIDTH-1:0] A_P1X = WIDTH'(P1XP);
   localparam logic [WIDTH-1:0] A_P1Y = WIDTH'(P1YP);
   localparam logic [WIDTH-1:0] A_P2X = WIDTH'(P2XP);
   localparam logic [WIDTH-1:0] A_P2Y = WIDTH'(P2YP);

   state_t           r_state, w_state_nxt;
   idx_t             r_idx, w_idx_nxt;
   logic             w_issue;
   logic             w_commit;
   logic [WIDTH-1:0] w_addr;
   logic             w_tag_vld;
   idx_t             w_tag_idx;
   logic             r_done;
   logic             r_overrun;
   logic [WIDTH-1:0] w_shadow [NUM_POS_WORDS];
   logic [WIDTH-1:0] w_pos    [NUM_POS_WORDS];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= IDX_MX;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (bus.frame_start) begin
               w_state_nxt = ST_FETCH;
               w_idx_nxt   = IDX_MX;
            end
         end
         ST_FETCH: begin
            if (r_idx == IDX_P2Y) w_state_nxt = ST_DRAIN;
            else                  w_idx_nxt   = idx_next(r_idx);
         end
         ST_DRAIN: begin
            // Leave once the final read's tag lines up with data_a; this
            // takes exactly READ_LATENCY cycles after the last issue.
            if (w_tag_vld && (w_tag_idx == IDX_P2Y)) w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_issue  = 1'b0;
      w_commit = 1'b0;
      w_addr   = A_MX;
      case (r_state)
         ST_IDLE: w_addr = A_MX;
         ST_FETCH: begin
            w_issue = idx_legal(r_idx);
            case (r_idx)
               IDX_MX:  w_addr = A_MX;
               IDX_MY:  w_addr = A_MY;
               IDX_P1X: w_addr = A_P1X;
               IDX_P1Y: w_addr = A_P1Y;
               IDX_P2X: w_addr = A_P2X;
               IDX_P2Y: w_addr = A_P2Y;
               default: w_addr = A_MX;
            endcase
         end
         ST_DRAIN: w_addr = A_P2Y;
         ST_COMMIT: begin
            w_addr   = A_P2Y;
            w_commit = 1'b1;
         end
         default: w_addr = A_MX;
      endcase
   end

   pos_tag_pipe #(
      .READ_LATENCY (READ_LATENCY)
   ) u_tag_pipe (
      .i_clk   (clk),
      .i_reset (reset),
      .i_vld   (w_issue),
      .i_idx   (r_idx),
      .o_vld   (w_tag_vld),
      .o_idx   (w_tag_idx)
   );

   for (genvar g = 0; g < NUM_POS_WORDS; g++) begin : g_pos
      flopenr #(.WIDTH(WIDTH)) u_shadow (
         .i_clk   (clk),
         .i_reset (reset),
         .i_en    (w_tag_vld && (w_tag_idx == idx_t'(g))),
         .i_d     (bus.data_a),
         .o_q     (w_shadow[g])
      );
      flopenr #(.WIDTH(WIDTH)) u_out (
         .i_clk   (clk),
         .i_reset (reset),
         .i_en    (w_commit),
         .i_d     (w_shadow[g]),
         .o_q     (w_pos[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (bus.frame_start && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      end
   end

   assign bus.addr_a  = w_addr;
   assign bus.busy    = (r_state != ST_IDLE);
   assign bus.done    = r_done;
   assign bus.overrun = r_overrun;
   assign bus.mx      = w_pos[IDX_MX];
   assign bus.my      = w_pos[IDX_MY];
   assign bus.p1x     = w_pos[IDX_P1X];
   assign bus.p1y     = w_pos[IDX_P1Y];
   assign bus.p2x     = w_pos[IDX_P2X];
   assign bus.p2y     = w_pos[IDX_P2Y];

endmodule
